loc_stepper: RTL and testbench
==============================

Name: loc_stepper

Overview:
- Parametrised successor to the maze-walker location datapath.
- Holds the current {X,Y} location in a register and applies one-step moves in four directions, with bounds checking.
- Records every accepted move in a LIFO move-history stack, so the controller can backtrack by popping and applying the inverse move.
- Sits between the maze controller FSM and the maze-memory address path; cur_loc drives the memory address.

Parameters:
- COORD_W, 4: bit width of each coordinate; location is 2*COORD_W bits, {X,Y}.
- DEPTH, 16: move-history entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH): stack pointer width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command this cycle
- cmd_op  in  2  00 LOAD, 01 MOVE, 10 BACK, 11 CLEAR
- cmd_dir  in  2  MOVE direction: 00 Y-1, 01 X+1, 10 X-1, 11 Y+1
- load_loc  in  2*COORD_W  LOAD value {X,Y}
- cur_loc  out  2*COORD_W  registered current location {X,Y}
- loc_valid  out  1  cur_loc has been loaded
- at_origin  out  1  cur_loc == 0 (combinational from register)
- depth  out  PTR_W+1  number of entries on the stack
- full  out  1  depth == DEPTH
- empty  out  1  depth == 0
- err  out  1  one-cycle pulse: accepted command was rejected (no state change)

Behaviour:
- Reset (async, any state): state = UNLOADED; cur_loc = 0; loc_valid = 0; depth = 0; err = 0; cmd_ready = 1. Stack RAM contents are don't-care.
- A command transfers when cmd_valid && cmd_ready are both high at a rising edge.
- Direction decode:
  - axis = ^dir: 1 selects X, 0 selects Y.
  - delta = +1 if dir[0] else -1.
  - inverse(dir) = ~dir.
- Bounds check:
  - A step is illegal if it would take the selected coordinate below 0 or above 2^COORD_W-1.
  - No wrap-around.
- FSM states: UNLOADED, IDLE, POP.
- UNLOADED:
  - cmd_ready = 1.
  - LOAD: cur_loc <= load_loc, loc_valid <= 1, depth <= 0, go to IDLE.
  - Any other op: err pulse, stay in UNLOADED.
- IDLE, cmd_ready = 1:
  - LOAD: cur_loc <= load_loc, depth <= 0, no err.
  - MOVE, legal and !full: cur_loc updated, cmd_dir pushed at stack[depth], depth += 1. Latency 1 cycle; cur_loc shows the new value the cycle after the transfer.
  - MOVE, illegal or full: err pulse, nothing changes.
  - BACK, !empty: issue synchronous RAM read at depth-1, go to POP. The pop is the only multi-cycle op.
  - BACK, empty: err pulse, stay in IDLE.
  - CLEAR: depth <= 0, cur_loc unchanged.
- POP:
  - cmd_ready = 0.
  - Apply inverse(popped dir) to cur_loc, depth -= 1, return to IDLE.
  - The inverse step is always legal by construction; no bounds check needed.
  - BACK-to-IDLE total is 2 cycles; cur_loc updates on the POP exit edge.
- err is registered and high for exactly one cycle after the offending transfer.
- Simultaneous push and pop cannot occur, because only one op is accepted per transfer.
- Reset asserted during POP aborts the pop; the state after reset is UNLOADED.
- Arithmetic is COORD_W-bit; the carry/borrow out is used only for the bounds check.

Decomposition:
- Shared package loc_pkg holds:
  - cmd_op encodings (OP_LOAD, OP_MOVE, OP_BACK, OP_CLEAR).
  - Direction encodings (DIR_YDN=00, DIR_XUP=01, DIR_XDN=10, DIR_YUP=11).
  - State encodings.
- One sub-module, move_stack:
  - DEPTH x 2-bit synchronous-read RAM.
  - Single write port and single read port; no reset on the array.
  - Pointer and depth logic stay in loc_stepper.

Test Plan:
- Reset, then MOVE: err pulses, loc_valid=0; LOAD 0x35 -> cur_loc=0x35, loc_valid=1, depth=0, at_origin=0.
- LOAD 0x00; MOVE 01, 01, 11 -> cur_loc 0x10, 0x20, 0x21; depth=3. Then BACK x3 -> each BACK shows cmd_ready=0 for one cycle; cur_loc 0x20, 0x10, 0x00; at_origin=1; empty=1.
- Boundary checks, COORD_W=4:
  - LOAD 0xF0, MOVE 01 -> err, cur_loc stays 0xF0, depth=0.
  - MOVE 00 at Y=0 -> err, no change.
  - LOAD 0x0F, MOVE 11 -> err.
- Full stack: DEPTH=16, LOAD 0x00, 16 alternating MOVE 01/10 -> full=1, depth=16; 17th MOVE -> err, cur_loc unchanged. BACK on empty after CLEAR -> err.
- Reset asserted in POP cycle -> immediately cur_loc=0, loc_valid=0, depth=0; state UNLOADED (MOVE -> err).
- Parameter sweep: COORD_W=6, DEPTH=4, LOAD {63,0}, MOVE 10 -> cur_loc {62,0}; MOVE 00 -> err; 4 legal moves -> full=1.

Source files
------------

// File: rtl/loc_pkg.sv
// Shared encodings for the location stepper: command ops, move directions, FSM states
// and the small direction-decode helpers.
package loc_pkg;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_MOVE  = 2'b01,
      OP_BACK  = 2'b10,
      OP_CLEAR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      DIR_YDN = 2'b00,
      DIR_XUP = 2'b01,
      DIR_XDN = 2'b10,
      DIR_YUP = 2'b11
   } dir_e;

   typedef enum logic [1:0] {
      ST_UNLOADED = 2'b00,
      ST_IDLE     = 2'b01,
      ST_POP      = 2'b10
   } state_e;

   // Encodings are chosen so that odd parity means the X axis and bit 0 gives the sign.
   function automatic logic dir_axis_x(input logic [1:0] dir);
      return ^dir;
   endfunction

   function automatic logic [1:0] dir_inverse(input logic [1:0] dir);
      return ~dir;
   endfunction

endpackage

// File: rtl/move_stack.sv
// Move-history storage: DEPTH x 2-bit RAM, one write port, one registered read port.
// The array carries no reset; only the pointer logic in the parent is reset.
module move_stack #(
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [PTR_W-1:0] i_waddr,
   input  logic [1:0]       i_wdata,
   input  logic             i_re,
   input  logic [PTR_W-1:0] i_raddr,
   output logic [1:0]       o_rdata
);

   logic [1:0] r_mem [DEPTH];
   logic [1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/loc_stepper.sv
// Current {X,Y} location register with bounded one-step moves and a LIFO move history
// that lets the maze controller backtrack by popping and applying the inverse step.
module loc_stepper
   import loc_pkg::*;
#(
   parameter  int COORD_W = 4,
   parameter  int DEPTH   = 16,
   localparam int PTR_W   = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic [1:0]           cmd_dir,
   input  logic [2*COORD_W-1:0] load_loc,
   output logic [2*COORD_W-1:0] cur_loc,
   output logic                 loc_valid,
   output logic                 at_origin,
   output logic [PTR_W:0]       depth,
   output logic                 full,
   output logic                 empty,
   output logic                 err
);

   localparam logic [PTR_W:0] DEPTH_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] DEPTH_ONE  = (PTR_W+1)'(1);

   state_e               r_state, w_state_nxt;
   logic [2*COORD_W-1:0] r_loc, w_loc_nxt;
   logic                 r_loc_valid, w_loc_valid_nxt;
   logic [PTR_W:0]       r_depth, w_depth_nxt;
   logic                 r_err, w_err_nxt;

   op_e                  w_op;
   logic                 w_xfer, w_full, w_empty, w_push, w_pop_rd;
   logic [PTR_W:0]       w_depth_inc, w_depth_dec;
   logic [1:0]           w_pop_dir, w_step_dir;
   logic                 w_axis_x;
   logic [COORD_W-1:0]   w_coord;
   logic [COORD_W:0]     w_coord_sum;
   logic                 w_step_oob;
   logic [2*COORD_W-1:0] w_step_loc;

   assign w_op        = op_e'(cmd_op);
   assign w_xfer      = cmd_valid && cmd_ready;
   assign w_full      = (r_depth == DEPTH_FULL);
   assign w_empty     = (r_depth == '0);
   assign w_depth_inc = r_depth + DEPTH_ONE;
   assign w_depth_dec = r_depth - DEPTH_ONE;

   // In POP the stepper reuses the same adder to apply the inverse of the popped move.
   assign w_step_dir = (r_state == ST_POP) ? dir_inverse(w_pop_dir) : cmd_dir;
   assign w_axis_x   = dir_axis_x(w_step_dir);

   // One-step adder on the selected coordinate; the extra MSB flags over/underflow.
   always_comb begin
      w_coord    = w_axis_x ? r_loc[2*COORD_W-1:COORD_W] : r_loc[COORD_W-1:0];
      w_step_loc = r_loc;
      if (w_step_dir[0]) begin
         w_coord_sum = {1'b0, w_coord} + {{COORD_W{1'b0}}, 1'b1};
      end else begin
         w_coord_sum = {1'b0, w_coord} - {{COORD_W{1'b0}}, 1'b1};
      end
      w_step_oob = w_coord_sum[COORD_W];
      if (w_axis_x) begin
         w_step_loc[2*COORD_W-1:COORD_W] = w_coord_sum[COORD_W-1:0];
      end else begin
         w_step_loc[COORD_W-1:0] = w_coord_sum[COORD_W-1:0];
      end
   end

   // Next-state and datapath update; any rejected transfer only raises err.
   always_comb begin
      w_state_nxt     = r_state;
      w_loc_nxt       = r_loc;
      w_loc_valid_nxt = r_loc_valid;
      w_depth_nxt     = r_depth;
      w_err_nxt       = 1'b0;
      w_push          = 1'b0;
      w_pop_rd        = 1'b0;
      case (r_state)
         ST_UNLOADED: begin
            if (w_xfer) begin
               if (w_op == OP_LOAD) begin
                  w_loc_nxt       = load_loc;
                  w_loc_valid_nxt = 1'b1;
                  w_depth_nxt     = '0;
                  w_state_nxt     = ST_IDLE;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end else begin
               w_state_nxt = ST_UNLOADED;
            end
         end
         ST_IDLE: begin
            if (w_xfer) begin
               case (w_op)
                  OP_LOAD: begin
                     w_loc_nxt   = load_loc;
                     w_depth_nxt = '0;
                  end
                  OP_MOVE: begin
                     if (w_step_oob || w_full) begin
                        w_err_nxt = 1'b1;
                     end else begin
                        w_loc_nxt   = w_step_loc;
                        w_depth_nxt = w_depth_inc;
                        w_push      = 1'b1;
                     end
                  end
                  OP_BACK: begin
                     if (w_empty) begin
                        w_err_nxt = 1'b1;
                     end else begin
                        w_pop_rd    = 1'b1;
                        w_state_nxt = ST_POP;
                     end
                  end
                  OP_CLEAR: begin
                     w_depth_nxt = '0;
                  end
                  default: begin
                     w_err_nxt = 1'b1;
                  end
               endcase
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_POP: begin
            w_loc_nxt   = w_step_loc;
            w_depth_nxt = w_depth_dec;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_UNLOADED;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_UNLOADED;
         r_loc       <= '0;
         r_loc_valid <= 1'b0;
         r_depth     <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_loc       <= w_loc_nxt;
         r_loc_valid <= w_loc_valid_nxt;
         r_depth     <= w_depth_nxt;
         r_err       <= w_err_nxt;
      end
   end

   move_stack #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_move_stack (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_depth[PTR_W-1:0]),
      .i_wdata (cmd_dir),
      .i_re    (w_pop_rd),
      .i_raddr (w_depth_dec[PTR_W-1:0]),
      .o_rdata (w_pop_dir)
   );

   assign cmd_ready = (r_state != ST_POP);
   assign cur_loc   = r_loc;
   assign loc_valid = r_loc_valid;
   assign at_origin = (r_loc == '0);
   assign depth     = r_depth;
   assign full      = w_full;
   assign empty     = w_empty;
   assign err       = r_err;

endmodule

// File: tb/tb_loc_stepper.sv
// Scoreboard bench for loc_stepper: default instance (COORD_W=4, DEPTH=16) and a
// COORD_W=6, DEPTH=4 instance sharing clock and reset.
module tb_loc_stepper;
   import loc_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic       a_valid, a_ready, a_lv, a_orig, a_full, a_empty, a_err;
   logic [1:0] a_op, a_dir;
   logic [7:0] a_load, a_loc;
   logic [4:0] a_depth;

   logic        b_valid, b_ready, b_lv, b_orig, b_full, b_empty, b_err;
   logic [1:0]  b_op, b_dir;
   logic [11:0] b_load, b_loc;
   logic [2:0]  b_depth;

   loc_stepper u_dut_a (
      .clk(clk), .rst(rst), .cmd_valid(a_valid), .cmd_ready(a_ready), .cmd_op(a_op),
      .cmd_dir(a_dir), .load_loc(a_load), .cur_loc(a_loc), .loc_valid(a_lv),
      .at_origin(a_orig), .depth(a_depth), .full(a_full), .empty(a_empty), .err(a_err)
   );

   loc_stepper #(.COORD_W(6), .DEPTH(4)) u_dut_b (
      .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_op(b_op),
      .cmd_dir(b_dir), .load_loc(b_load), .cur_loc(b_loc), .loc_valid(b_lv),
      .at_origin(b_orig), .depth(b_depth), .full(b_full), .empty(b_empty), .err(b_err)
   );

   typedef struct packed {
      logic [15:0] loc;
      logic        valid;
      logic [7:0]  depth;
      logic        err;
      logic [3:0]  busy;
      logic        full;
      logic        empty;
      logic        orig;
   } res_t;

   res_t exp_q[$];
   res_t obs_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   function automatic res_t mk(input bit sel, input logic [15:0] loc, input logic valid,
                               input logic [7:0] dep, input logic e, input logic [3:0] busy);
      res_t r;
      r.loc   = loc;
      r.valid = valid;
      r.depth = dep;
      r.err   = e;
      r.busy  = busy;
      r.full  = (dep == (sel ? 8'd4 : 8'd16));
      r.empty = (dep == 8'd0);
      r.orig  = (loc == 16'd0);
      return r;
   endfunction

   // Drive one command, wait for completion, record what the DUT shows afterwards.
   task automatic send(input bit sel, input logic [1:0] op, input logic [1:0] dir,
                       input logic [15:0] ld);
      res_t r;
      int   waitc;
      int   busy;
      @(negedge clk);
      if (sel) begin
         b_valid = 1'b1; b_op = op; b_dir = dir; b_load = ld[11:0];
      end else begin
         a_valid = 1'b1; a_op = op; a_dir = dir; a_load = ld[7:0];
      end
      waitc = 0;
      while ((sel ? b_ready : a_ready) !== 1'b1 && waitc < 8) begin
         @(negedge clk);
         waitc++;
      end
      n_checks++;
      if (waitc >= 8) begin
         n_errors++;
         $display("FAIL send_ready_timeout got waited=%0d need <8", waitc);
      end
      @(posedge clk);
      @(negedge clk);
      a_valid = 1'b0;
      b_valid = 1'b0;
      busy = 0;
      while ((sel ? b_ready : a_ready) !== 1'b1 && busy < 8) begin
         @(negedge clk);
         busy++;
      end
      if (sel) begin
         r = '{loc: {4'd0, b_loc}, valid: b_lv, depth: {5'd0, b_depth}, err: b_err,
               busy: 4'(busy), full: b_full, empty: b_empty, orig: b_orig};
      end else begin
         r = '{loc: {8'd0, a_loc}, valid: a_lv, depth: {3'd0, a_depth}, err: a_err,
               busy: 4'(busy), full: a_full, empty: a_empty, orig: a_orig};
      end
      obs_q.push_back(r);
   endtask

   task automatic ex(input bit sel, input logic [1:0] op, input logic [1:0] dir,
                     input logic [15:0] ld, input logic [15:0] loc, input logic valid,
                     input logic [7:0] dep, input logic e, input logic [3:0] busy);
      exp_q.push_back(mk(sel, loc, valid, dep, e, busy));
      send(sel, op, dir, ld);
   endtask

   task automatic test_reset;
      n_checks++;
      if ({a_loc, a_lv, a_depth, a_err, a_ready, a_empty, a_orig, a_full} !==
          {8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
         n_errors++;
         $display("FAIL reset_a got loc=%h lv=%b d=%0d err=%b rdy=%b empty=%b orig=%b full=%b need 00 0 0 0 1 1 1 0",
                  a_loc, a_lv, a_depth, a_err, a_ready, a_empty, a_orig, a_full);
      end
      n_checks++;
      if ({b_loc, b_lv, b_depth, b_err, b_ready} !== {12'h000, 1'b0, 3'd0, 1'b0, 1'b1}) begin
         n_errors++;
         $display("FAIL reset_b got loc=%h lv=%b d=%0d err=%b rdy=%b need 000 0 0 0 1",
                  b_loc, b_lv, b_depth, b_err, b_ready);
      end
   endtask

   task automatic test_move_back;
      res_t e, o;
      int   k;
      ex(0, OP_MOVE,  DIR_XUP, 16'h00, 16'h00, 1'b0, 8'd0, 1'b1, 4'd0);
      ex(0, OP_BACK,  DIR_XUP, 16'h00, 16'h00, 1'b0, 8'd0, 1'b1, 4'd0);
      ex(0, OP_LOAD,  DIR_XUP, 16'h35, 16'h35, 1'b1, 8'd0, 1'b0, 4'd0);
      ex(0, OP_LOAD,  DIR_XUP, 16'h00, 16'h00, 1'b1, 8'd0, 1'b0, 4'd0);
      ex(0, OP_MOVE,  DIR_XUP, 16'h00, 16'h10, 1'b1, 8'd1, 1'b0, 4'd0);
      ex(0, OP_MOVE,  DIR_XUP, 16'h00, 16'h20, 1'b1, 8'd2, 1'b0, 4'd0);
      ex(0, OP_MOVE,  DIR_YUP, 16'h00, 16'h21, 1'b1, 8'd3, 1'b0, 4'd0);
      ex(0, OP_BACK,  DIR_XUP, 16'h00, 16'h20, 1'b1, 8'd2, 1'b0, 4'd1);
      ex(0, OP_BACK,  DIR_XUP, 16'h00, 16'h10, 1'b1, 8'd1, 1'b0, 4'd1);
      ex(0, OP_BACK,  DIR_XUP, 16'h00, 16'h00, 1'b1, 8'd0, 1'b0, 4'd1);
      ex(0, OP_BACK,  DIR_XUP, 16'h00, 16'h00, 1'b1, 8'd0, 1'b1, 4'd0);
      ex(0, OP_MOVE,  DIR_XUP, 16'h00, 16'h10, 1'b1, 8'd1, 1'b0, 4'd0);
      ex(0, OP_CLEAR, DIR_XUP, 16'h00, 16'h10, 1'b1, 8'd0, 1'b0, 4'd0);
      ex(0, OP_MOVE,  DIR_YUP, 16'h00, 16'h11, 1'b1, 8'd1, 1'b0, 4'd0);
      ex(0, OP_LOAD,  DIR_XUP, 16'h77, 16'h77, 1'b1, 8'd0, 1'b0, 4'd0);
      k = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_errors++;
            $display("FAIL move_back step %0d got %h need %h (loc,valid,depth,err,busy,full,empty,orig)", k, o, e);
         end
         k++;
      end
   endtask

   task automatic test_bounds;
      res_t e, o;
      int   k;
      ex(0, OP_LOAD, DIR_XUP, 16'hF0, 16'hF0, 1'b1, 8'd0, 1'b0, 4'd0);
      ex(0, OP_MOVE, DIR_XUP, 16'h00, 16'hF0, 1'b1, 8'd0, 1'b1, 4'd0);
      @(negedge clk);
      n_checks++;
      if (a_err !== 1'b0) begin
         n_errors++;
         $display("FAIL err_one_cycle got err=%b need 0", a_err);
      end
      ex(0, OP_MOVE, DIR_YDN, 16'h00, 16'hF0, 1'b1, 8'd0, 1'b1, 4'd0);
      ex(0, OP_MOVE, DIR_XDN, 16'h00, 16'hE0, 1'b1, 8'd1, 1'b0, 4'd0);
      ex(0, OP_LOAD, DIR_XUP, 16'h0F, 16'h0F, 1'b1, 8'd0, 1'b0, 4'd0);
      ex(0, OP_MOVE, DIR_YUP, 16'h00, 16'h0F, 1'b1, 8'd0, 1'b1, 4'd0);
      ex(0, OP_MOVE, DIR_XDN, 16'h00, 16'h0F, 1'b1, 8'd0, 1'b1, 4'd0);
      ex(0, OP_MOVE, DIR_YDN, 16'h00, 16'h0E, 1'b1, 8'd1, 1'b0, 4'd0);
      k = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_errors++;
            $display("FAIL bounds step %0d got %h need %h (loc,valid,depth,err,busy,full,empty,orig)", k, o, e);
         end
         k++;
      end
   endtask

   task automatic test_full;
      res_t e, o;
      int   k;
      ex(0, OP_LOAD, DIR_XUP, 16'h00, 16'h00, 1'b1, 8'd0, 1'b0, 4'd0);
      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 0) ex(0, OP_MOVE, DIR_XUP, 16'h00, 16'h10, 1'b1, 8'(i + 1), 1'b0, 4'd0);
         else            ex(0, OP_MOVE, DIR_XDN, 16'h00, 16'h00, 1'b1, 8'(i + 1), 1'b0, 4'd0);
      end
      ex(0, OP_MOVE,  DIR_XUP, 16'h00, 16'h00, 1'b1, 8'd16, 1'b1, 4'd0);
      ex(0, OP_BACK,  DIR_XUP, 16'h00, 16'h10, 1'b1, 8'd15, 1'b0, 4'd1);
      ex(0, OP_CLEAR, DIR_XUP, 16'h00, 16'h10, 1'b1, 8'd0,  1'b0, 4'd0);
      ex(0, OP_BACK,  DIR_XUP, 16'h00, 16'h10, 1'b1, 8'd0,  1'b1, 4'd0);
      k = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_errors++;
            $display("FAIL full step %0d got %h need %h (loc,valid,depth,err,busy,full,empty,orig)", k, o, e);
         end
         k++;
      end
   endtask

   task automatic test_reset_in_pop;
      res_t e, o;
      int   k;
      ex(0, OP_LOAD, DIR_XUP, 16'h00, 16'h00, 1'b1, 8'd0, 1'b0, 4'd0);
      ex(0, OP_MOVE, DIR_YUP, 16'h00, 16'h01, 1'b1, 8'd1, 1'b0, 4'd0);
      @(negedge clk);
      a_valid = 1'b1; a_op = OP_BACK; a_dir = DIR_XUP;
      @(posedge clk);
      @(negedge clk);
      a_valid = 1'b0;
      n_checks++;
      if (a_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL pop_busy got ready=%b need 0", a_ready);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({a_loc, a_lv, a_depth, a_ready} !== {8'h00, 1'b0, 5'd0, 1'b1}) begin
         n_errors++;
         $display("FAIL reset_in_pop got loc=%h lv=%b d=%0d rdy=%b need 00 0 0 1",
                  a_loc, a_lv, a_depth, a_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      ex(0, OP_MOVE, DIR_YUP, 16'h00, 16'h00, 1'b0, 8'd0, 1'b1, 4'd0);
      k = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_errors++;
            $display("FAIL reset_pop step %0d got %h need %h (loc,valid,depth,err,busy,full,empty,orig)", k, o, e);
         end
         k++;
      end
   endtask

   task automatic test_param_sweep;
      res_t e, o;
      int   k;
      ex(1, OP_LOAD, DIR_XUP, 16'hFC0, 16'hFC0, 1'b1, 8'd0, 1'b0, 4'd0);
      ex(1, OP_MOVE, DIR_XDN, 16'h000, 16'hF80, 1'b1, 8'd1, 1'b0, 4'd0);
      ex(1, OP_MOVE, DIR_YDN, 16'h000, 16'hF80, 1'b1, 8'd1, 1'b1, 4'd0);
      ex(1, OP_MOVE, DIR_XUP, 16'h000, 16'hFC0, 1'b1, 8'd2, 1'b0, 4'd0);
      ex(1, OP_MOVE, DIR_XUP, 16'h000, 16'hFC0, 1'b1, 8'd2, 1'b1, 4'd0);
      ex(1, OP_MOVE, DIR_YUP, 16'h000, 16'hFC1, 1'b1, 8'd3, 1'b0, 4'd0);
      ex(1, OP_MOVE, DIR_YUP, 16'h000, 16'hFC2, 1'b1, 8'd4, 1'b0, 4'd0);
      ex(1, OP_MOVE, DIR_YUP, 16'h000, 16'hFC2, 1'b1, 8'd4, 1'b1, 4'd0);
      ex(1, OP_BACK, DIR_XUP, 16'h000, 16'hFC1, 1'b1, 8'd3, 1'b0, 4'd1);
      k = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_errors++;
            $display("FAIL param_sweep step %0d got %h need %h (loc,valid,depth,err,busy,full,empty,orig)", k, o, e);
         end
         k++;
      end
   endtask

   initial begin
      rst = 1'b1;
      a_valid = 1'b0; a_op = 2'b00; a_dir = 2'b00; a_load = 8'h00;
      b_valid = 1'b0; b_op = 2'b00; b_dir = 2'b00; b_load = 12'h000;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_move_back();
      test_bounds();
      test_full();
      test_param_sweep();
      test_reset_in_pop();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
